// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: queued prediction entry and FSM state.
package bru_pkg;

    localparam int unsigned BRU_AW = 32;

    typedef struct packed {
        logic [BRU_AW-1:0] pc;
        logic [BRU_AW-1:0] pred_target;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } bru_state_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-flight prediction queue: DEPTH entries, wrap-bit pointers, synchronous flush,
// head entry visible combinationally.
module bru_pred_fifo
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  pred_entry_t din,
    output logic        full,
    output logic        empty,
    output pred_entry_t head
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    pred_entry_t   mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign pop_ok  = pop && !empty;
    // A full queue still takes a push when the head leaves on the same edge
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks queued fetch predictions against resolved branches; drives BTB update and redirect.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = BRU_AW,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [AW-1:0]    pred_pc,
    input  logic [AW-1:0]    pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic [AW-1:0]    res_pc,
    input  logic             res_taken,
    input  logic [AW-1:0]    res_target,
    output logic             update,
    output logic [AW-1:0]    update_pc,
    output logic [AW-1:0]    update_target,
    output logic             redirect,
    output logic [AW-1:0]    redirect_pc,
    output logic             seq_err,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    bru_state_t  state, state_nxt;
    pred_entry_t head;
    pred_entry_t din;
    logic        full, empty;
    logic        push_c, pop_c, flush_c, accept_c;
    logic        update_d, redirect_d, seq_err_d;
    logic [AW-1:0] actual_next_c;

    assign din.pc          = pred_pc;
    assign din.pred_target = pred_target;
    assign actual_next_c   = res_taken ? res_target : res_pc + AW'(4);
    assign pred_ready      = !full && (state == RUN);
    // Wrong-path pushes on a flushing edge are discarded
    assign push_c          = pred_valid && pred_ready && !flush_c;

    bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Resolution compare and next-state
    always_comb begin
        state_nxt  = state;
        pop_c      = 1'b0;
        flush_c    = 1'b0;
        accept_c   = 1'b0;
        update_d   = 1'b0;
        redirect_d = 1'b0;
        seq_err_d  = 1'b0;
        case (state)
            RUN: begin
                if (res_valid) begin
                    if (empty) begin
                        seq_err_d = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        if (res_pc != head.pc) begin
                            seq_err_d  = 1'b1;
                            redirect_d = 1'b1;
                            flush_c    = 1'b1;
                        end else begin
                            pop_c    = 1'b1;
                            update_d = res_taken && (head.pred_target != res_target);
                            if (head.pred_target != actual_next_c) begin
                                redirect_d = 1'b1;
                                flush_c    = 1'b1;
                            end
                        end
                    end
                end
                if (redirect_d) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update        <= 1'b0;
            update_pc     <= '0;
            update_target <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            seq_err       <= 1'b0;
        end else begin
            update   <= update_d;
            redirect <= redirect_d;
            seq_err  <= seq_err_d;
            if (update_d) begin
                update_pc     <= res_pc;
                update_target <= res_target;
            end
            if (redirect_d) redirect_pc <= actual_next_c;
        end
    end

`ifdef BRU_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (accept_c && (stat_branches != '1)) stat_branches <= stat_branches + CNT_W'(1);
            if (redirect_d && (stat_mispred != '1)) stat_mispred <= stat_mispred + CNT_W'(1);
        end
    end
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule
